// File: rtl/das_accum.sv
// Delay-and-sum accumulator: sums N_CH consecutive delayed samples into one focal-point value.
// Optional per-channel apodization weighting is compiled in when DAS_APOD_EN is defined.
module das_accum #(
   parameter int DATA_WIDTH = 16,
   parameter int N_CH       = 8,
   parameter int CH_W       = 3,
   parameter int ACC_WIDTH  = 19,
   parameter int POINT_W    = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] din,
   input  logic                         din_valid,
   output logic                         din_ready,
   output logic signed [ACC_WIDTH-1:0]  sum_out,
   output logic                         sum_valid,
   input  logic                         sum_ready,
   output logic [CH_W-1:0]              ch_idx,
   output logic [POINT_W-1:0]           point_idx
);

   // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
   // valid never waits on ready, and a presented sum_out holds until it is taken.
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] din_ext;
   logic signed [ACC_WIDTH-1:0] term;
   logic                        last_ch;
   logic                        accept;
   logic                        consume;

   assign last_ch   = (ch_idx == CH_W'(N_CH - 1));
   assign consume   = sum_valid && sum_ready;
   // Only the closing channel needs a free output slot; earlier channels keep flowing.
   assign din_ready = !(last_ch && sum_valid && !sum_ready);
   assign accept    = din_valid && din_ready;
   assign din_ext   = ACC_WIDTH'(din);

`ifdef DAS_APOD_EN
   function automatic logic [7:0] apod_weight(input logic [CH_W-1:0] ch);
      logic [7:0] w;
      w = 8'd128;
      if (N_CH == 8) begin
         case (int'(ch))
            0, 7:    w = 8'd32;
            1, 6:    w = 8'd64;
            2, 5:    w = 8'd96;
            default: w = 8'd128;
         endcase
      end
      return w;
   endfunction

   logic signed [ACC_WIDTH+8:0] prod;

   // Weight is unsigned Q1.7; the arithmetic shift floors toward minus infinity.
   assign prod = din_ext * $signed({1'b0, apod_weight(ch_idx)});
   assign term = ACC_WIDTH'(prod >>> 7);
`else
   assign term = din_ext;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         ch_idx    <= '0;
         point_idx <= '0;
         sum_out   <= '0;
         sum_valid <= 1'b0;
      end else begin
         if (consume) begin
            sum_valid <= 1'b0;
            point_idx <= point_idx + POINT_W'(1);
         end
         // A final-channel accept after the consume above re-arms sum_valid in the same edge.
         if (accept) begin
            if (last_ch) begin
               sum_out   <= acc + term;
               sum_valid <= 1'b1;
               acc       <= '0;
               ch_idx    <= '0;
            end else begin
               acc    <= acc + term;
               ch_idx <= ch_idx + CH_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/das_accum.md
# das_accum

Delay-and-sum accumulator sitting directly downstream of the per-channel delay stage (`top_ultra`). It consumes delayed echo samples, one channel per accepted beat. It sums `N_CH` consecutive samples into one beamformed focal-point value and presents that value on a valid/ready output register. An optional apodization weight per channel is compiled in with a macro.

## Interface
- `DATA_WIDTH`, 16: width of signed two's-complement input sample.
- `N_CH`, 8: channels summed per focal point; must be ≥ 2.
- `CH_W`, 3: width of channel counter; must equal clog2(`N_CH`).
- `ACC_WIDTH`, 19: width of signed sum; must be ≥ `DATA_WIDTH` + `CH_W`.
- `POINT_W`, 10: width of focal-point counter.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `din` in `DATA_WIDTH`: signed delayed sample (upstream `dout`).
- `din_valid` in 1: `din` valid this cycle.
- `din_ready` out 1: block accepts `din` this cycle.
- `sum_out` out `ACC_WIDTH`: signed beamformed sum.
- `sum_valid` out 1: `sum_out` holds an unconsumed result.
- `sum_ready` in 1: downstream consumes `sum_out` when high with `sum_valid`.
- `ch_idx` out `CH_W`: channel index the next accepted sample is assigned to.
- `point_idx` out `POINT_W`: index of the focal point currently presented or next produced.

## Operation
- Reset values: `acc`=0, `ch_idx`=0, `point_idx`=0, `sum_out`=0, `sum_valid`=0. `din_ready` evaluates to 1 after reset.
- Accept: `din_valid && din_ready` on a rising edge.
- Extension: `din` is sign-extended to `ACC_WIDTH` and then weighted (see Configuration). The result is the term.
- Accept with `ch_idx` < `N_CH`-1:
  - `acc` <= `acc` + term.
  - `ch_idx` increments.
- Accept with `ch_idx` == `N_CH`-1:
  - `sum_out` <= `acc` + term.
  - `sum_valid` <= 1.
  - `acc` <= 0.
  - `ch_idx` <= 0.
- Output consume: when `sum_valid && sum_ready`, `sum_valid` clears next cycle and `point_idx` increments. `point_idx` wraps modulo 2^`POINT_W`.
- Simultaneous consume and final-channel accept: `sum_out` is loaded with the new sum. `sum_valid` stays 1. `point_idx` increments once.
- `din_ready` is combinational. It is 0 only when `ch_idx` == `N_CH`-1 && `sum_valid` && !`sum_ready`. Accumulation of channels 0..`N_CH`-2 of the next point continues while the output is held.
- Arithmetic: two's-complement. No saturation is needed because the width rule guarantees the sum fits (e.g. 8 × −32768 = −262144 fits in 19 bits).
- `sum_out` is stable while `sum_valid` && !`sum_ready`.
- Reset mid-accumulation discards the partial `acc` and any pending `sum_out`. All state returns to the reset values on the next edge.
- `din_valid` low: no state change to `acc`/`ch_idx`. The output side operates independently.

## Timing
- Latency: `sum_valid` rises on the edge that accepts channel `N_CH`-1. It is visible the cycle after `din` was presented.
- Throughput: one sample per cycle sustained while `sum_ready` is held high. One result every `N_CH` cycles.
- The output register is one deep. No skid buffer beyond it.
- No combinational path from `din` to `sum_out`. The only combinational path from `sum_ready` is to `din_ready`.

## Configuration
- `DAS_APOD_EN` defined: each term is (`din` × w[`ch_idx`]) >>> 7, using an arithmetic shift (floor).
  - For `N_CH`==8 the unsigned Q1.7 weights are 32, 64, 96, 128, 128, 96, 64, 32.
  - For any other `N_CH` every weight is 128 (unity).
  - Latency is unchanged; the multiply is in the accept path.
- `DAS_APOD_EN` undefined: term = sign-extended `din` (unity weight). No multiplier is instantiated.

## Test plan
- Basic sum: with `sum_ready`=1, 8 back-to-back samples of 100 -> one `sum_valid` pulse with `sum_out`=800. `point_idx` goes 0→1. `din_ready` stays 1.
- Signed full-scale: 8 samples of −32768 -> `sum_out`=−262144. Then 8 samples of 32767 -> `sum_out`=262136.
- Backpressure: hold `sum_ready`=0 and send 15 samples of 1 -> `sum_out`=8 held stable. `ch_idx`=7 and `din_ready`=0. Raise `sum_ready` -> the 16th sample is accepted in the same cycle and `sum_out`=8 again. `point_idx` increments once for that cycle.
- Reset mid-point: accept 5 samples of 50, then assert `reset` for one cycle, then send 8 samples of 10 -> `sum_out`=80 (not 330). `point_idx`=0 before the consume.
- Bubbles: `din_valid` toggles 1/0 across 16 cycles with samples 1..8 -> `sum_out`=36. `ch_idx` advances only on accepted beats.
- `DAS_APOD_EN` build: 8 samples of 256 -> `sum_out`=1280. 8 samples of −1 -> `sum_out`=−8 (floor of each term).
